imem_program_loader: RTL and testbench

- Sits upstream of the instruction memory and the core.
- Accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them sequentially into the instruction memory write port.
- Holds the core in reset until a complete program has loaded, then releases it.
- Records the program length and flags when the core PC runs past the last loaded instruction, so the PC can be restarted at 0.

---
 rtl/imem_program_loader.sv | 100 ++++++++++
 tb/tb_imem_program_loader.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_program_loader.sv
// Program loader: streams instruction words into the instruction memory write port,
// holds the core in reset until a full program is present, and flags PC run-off.
//
// state | meaning
// IDLE  | out of reset, no program loaded yet
// LOAD  | accepting words and writing them to sequential addresses
// RUN   | program complete, core released, pc_wrap active
// ERROR | load overran DEPTH without word_last; core held in reset
module imem_program_loader #(
  parameter int DEPTH = 256,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_start,
  input  logic             word_valid,
  output logic             word_ready,
  input  logic [31:0]      word_data,
  input  logic             word_last,
  output logic             imem_we,
  output logic [31:0]      imem_waddr,
  output logic [31:0]      imem_wdata,
  output logic             core_reset,
  output logic [CNT_W-1:0] instr_count,
  input  logic [31:0]      pc_in,
  output logic             pc_wrap,
  output logic             load_err
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, ERROR} state_t;

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(DEPTH - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] count, count_nxt, instr_count_nxt;
  logic             load_err_nxt;
  logic             xfer;
  logic [31:0]      prog_end;

  // Outputs are gated by reset so the reset cycle itself is already quiet.
  assign word_ready = !reset && (state == LOAD);
  assign xfer       = word_valid && word_ready;
  assign imem_we    = xfer;
  assign imem_waddr = 32'({count, 2'b00});
  assign imem_wdata = word_data;
  assign core_reset = reset || (state != RUN);
  assign prog_end   = 32'({instr_count, 2'b00});
  assign pc_wrap    = !reset && (state == RUN) && (pc_in >= prog_end);

  always_comb begin
    state_nxt       = state;
    count_nxt       = count;
    instr_count_nxt = instr_count;
    load_err_nxt    = load_err;
    case (state)
      IDLE, RUN: begin
        if (load_start) begin
          state_nxt = LOAD;
          count_nxt = '0;
        end
      end
      ERROR: begin
        if (load_start) begin
          state_nxt    = LOAD;
          count_nxt    = '0;
          load_err_nxt = 1'b0;
        end
      end
      LOAD: begin
        if (xfer) begin
          count_nxt = count + 1'b1;
          // word_last takes priority, so a program of exactly DEPTH words is legal.
          if (word_last) begin
            instr_count_nxt = count + 1'b1;
            state_nxt       = RUN;
          end else if (count == LAST_IDX) begin
            load_err_nxt = 1'b1;
            state_nxt    = ERROR;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      instr_count <= '0;
      load_err    <= 1'b0;
    end else begin
      state       <= state_nxt;
      count       <= count_nxt;
      instr_count <= instr_count_nxt;
      load_err    <= load_err_nxt;
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Bench for imem_program_loader: randomized loads with stalls, overflow, resets;
// IMEM writes go through a scoreboard queue, status outputs against a phase model.
module tb_imem_program_loader;
  localparam int DEPTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             reset, load_start, word_valid, word_last;
  logic [31:0]      word_data, pc_in;
  logic             word_ready, imem_we, core_reset, pc_wrap, load_err;
  logic [31:0]      imem_waddr, imem_wdata;
  logic [CNT_W-1:0] instr_count;

  imem_program_loader #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .load_start(load_start),
    .word_valid(word_valid), .word_ready(word_ready), .word_data(word_data),
    .word_last(word_last), .imem_we(imem_we), .imem_waddr(imem_waddr),
    .imem_wdata(imem_wdata), .core_reset(core_reset), .instr_count(instr_count),
    .pc_in(pc_in), .pc_wrap(pc_wrap), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  int  n_tests = 0;
  int  n_fail  = 0;
  wr_t exp_q[$];
  // Reference view of the loader: 0 idle, 1 loading, 2 running, 3 overflowed.
  int  m_phase = 0;
  int  m_instr = 0;
  bit  m_err   = 1'b0;
  bit  mon_en  = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      chk("core_reset", 64'(core_reset), 64'(reset || (m_phase != 2)));
      chk("word_ready", 64'(word_ready), 64'(!reset && (m_phase == 1)));
      chk("instr_count", 64'(instr_count), 64'(m_instr));
      chk("load_err", 64'(load_err), 64'(m_err));
      chk("pc_wrap", 64'(pc_wrap),
          64'(!reset && (m_phase == 2) && (64'(pc_in) >= 64'(m_instr) * 4)));
      if (imem_we) begin
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_write: got write addr 0x%0h, expected no write", imem_waddr);
        end else begin
          wr_t e;
          e = exp_q.pop_front();
          chk("imem_waddr", 64'(imem_waddr), 64'(e.addr));
          chk("imem_wdata", 64'(imem_wdata), 64'(e.data));
        end
      end
      if (exp_q.size() != 0) begin
        chk("missing_write", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    case ($urandom_range(0, 4))
      0:       pc_in = 32'(m_instr * 4);
      1:       pc_in = 32'(m_instr * 4) - 32'd4;
      2:       pc_in = 32'hFFFF_FFFC;
      3:       pc_in = $urandom & 32'h0000_003C;
      default: pc_in = $urandom;
    endcase
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      load_start = 1'b0;
      word_valid = 1'($urandom_range(0, 1));
      word_last  = 1'($urandom_range(0, 1));
      word_data  = $urandom;
      tick();
    end
    word_valid = 1'b0;
    word_last  = 1'b0;
  endtask

  task automatic run_load(input logic [31:0] words[$], input int max_stall, input bit last_at_end,
                          input int stall_idx, input int stall_len);
    load_start = 1'b1;
    word_valid = 1'b0;
    word_last  = 1'b0;
    tick();
    m_phase = 1;
    m_err   = 1'b0;
    for (int i = 0; i < words.size(); i++) begin
      int st;
      st = (i == stall_idx) ? stall_len : ((max_stall > 0) ? $urandom_range(0, max_stall) : 0);
      for (int s = 0; s < st; s++) begin
        word_valid = 1'b0;
        word_last  = 1'($urandom_range(0, 1));
        load_start = 1'($urandom_range(0, 1));
        word_data  = $urandom;
        tick();
      end
      word_valid = 1'b1;
      word_data  = words[i];
      word_last  = last_at_end && (i == words.size() - 1);
      load_start = 1'($urandom_range(0, 1));
      exp_q.push_back('{addr: 32'(i * 4), data: words[i]});
      tick();
      if (last_at_end && (i == words.size() - 1)) begin
        m_phase = 2;
        m_instr = i + 1;
      end else if (i == DEPTH - 1) begin
        m_phase = 3;
        m_err   = 1'b1;
      end
    end
    word_valid = 1'b0;
    word_last  = 1'b0;
    load_start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] prog[$];
    logic [31:0] w[$];
    int          len;
    bit          last;

    reset = 1'b1; load_start = 1'b0; word_valid = 1'b0; word_last = 1'b0;
    word_data = '0; pc_in = '0;
    tick();
    mon_en = 1'b1;
    tick();
    reset = 1'b0;
    idle(2);

    prog = '{32'h00306293, 32'h00428313, 32'h0062A2A3, 32'h0052A383, 32'hFE7306E3};
    run_load(prog, 0, 1'b1, -1, 0);
    pc_in = 32'd16;
    tick(); pc_in = 32'd20;
    tick(); pc_in = 32'hFFFF_FFFC;
    tick(); pc_in = 32'd16;
    idle(2);

    run_load(prog, 0, 1'b1, 2, 3);
    idle(2);

    // Reload from RUN; instr_count must keep 5 until the new load finishes.
    w = '{$urandom, $urandom};
    run_load(w, 2, 1'b1, -1, 0);
    idle(2);

    w.delete();
    for (int k = 0; k < DEPTH; k++) w.push_back($urandom);
    run_load(w, 1, 1'b0, -1, 0);
    idle(3);
    w = '{32'h0000_0013};
    run_load(w, 0, 1'b1, -1, 0);
    idle(2);

    // Reset in the middle of a load with word_valid held high.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    m_phase = 1;
    for (int k = 0; k < 2; k++) begin
      word_valid = 1'b1;
      word_last  = 1'b0;
      word_data  = $urandom;
      exp_q.push_back('{addr: 32'(k * 4), data: word_data});
      tick();
    end
    reset = 1'b1;
    word_valid = 1'b1;
    tick();
    reset = 1'b0;
    m_phase = 0; m_instr = 0; m_err = 1'b0;
    for (int k = 0; k < 3; k++) begin
      word_valid = 1'b1;
      word_data  = $urandom;
      tick();
    end
    word_valid = 1'b0;

    run_load(prog, 0, 1'b1, -1, 0);
    idle(2);
    reset = 1'b1;
    load_start = 1'b1;
    tick();
    reset = 1'b0;
    load_start = 1'b0;
    m_phase = 0; m_instr = 0; m_err = 1'b0;
    idle(3);

    for (int it = 0; it < 40; it++) begin
      len  = $urandom_range(1, DEPTH);
      last = (len < DEPTH) ? 1'b1 : 1'($urandom_range(0, 1));
      w.delete();
      for (int k = 0; k < len; k++) w.push_back($urandom);
      run_load(w, 3, last, -1, 0);
      idle($urandom_range(1, 4));
    end

    tick();
    mon_en = 1'b0;
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
